bit_deserializer: RTL and testbench
===================================

Name: bit_deserializer

Overview:
- Sits directly downstream of the recovered-clock generator in the serial receive path. Its recovered clock level clk_gen_o drives clk_rec_i here.
- Samples data_i at mid-bit on each falling edge of clk_rec_i and hunts for a sync pattern.
- After sync, deserializes a fixed-length frame of words and presents each word on a valid/ready interface.
- Flags overrun and loss of recovered clock.

Parameters:
- DW, 8, data word width in bits (>=2).
- SYNC_W, 8, sync pattern width in bits.
- SYNC_PAT, 8'hD5, sync pattern; the first received bit of the pattern is the MSB.
- FRAME_WORDS, 4, words per frame after sync (>=1).
- TMO_W, 8, timeout counter width; timeout occurs at 2**TMO_W-1 clk_i cycles without a sample strobe.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- data_i  in  1  serial data, synchronous to clk_i
- clk_rec_i  in  1  recovered clock level, synchronous to clk_i
- en_i  in  1  receiver enable
- word_o  out  DW  received word, MSB = first bit received
- valid_o  out  1  word_o valid
- ready_i  in  1  consumer accepts word_o
- locked_o  out  1  high while in RECV state
- frame_end_o  out  1  one-cycle pulse when the last word of a frame is loaded
- overrun_o  out  1  one-cycle pulse when a completed word is dropped
- timeout_o  out  1  one-cycle pulse when clock loss forces HUNT
- parity_err_o  out  1  one-cycle pulse on parity mismatch (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0.
  - State HUNT; shift, bit, word and timeout counters 0.
  - clk_rec_q = 0.
- Strobe generation:
  - clk_rec_q registers clk_rec_i.
  - stb = clk_rec_q & ~clk_rec_i (falling edge). On stb, data_i is sampled in the same cycle.
- en_i = 0: the next edge forces HUNT, clears the counters and the sync shifter, and drops locked_o. A pending valid_o/word_o is held until accepted.
- HUNT:
  - On stb: sync_sr <= {sync_sr[SYNC_W-2:0], data_i}.
  - When the shifted value equals SYNC_PAT (compared on the new value, in the stb cycle), the next state is RECV with bit_cnt = 0 and word_cnt = 0.
  - sync_sr is not cleared on match.
- RECV:
  - On stb, shift data_i into data_sr MSB-first and increment bit_cnt.
  - On the stb carrying bit DW-1, the completed word is handed to the output stage at the next edge, bit_cnt wraps to 0, and word_cnt increments.
  - When word_cnt reaches FRAME_WORDS-1 and that word completes: pulse frame_end_o, clear sync_sr, return to HUNT.
- Output stage:
  - On completion, if valid_o = 0 or ready_i = 1: word_o <= new word, valid_o <= 1 (latency 1 clk_i cycle after the last-bit stb).
  - If valid_o = 1 and ready_i = 0: the new word is dropped, overrun_o pulses, and word_o is unchanged. FSM progress continues and word_cnt still counts the dropped word.
  - valid_o & ready_i with no completion: valid_o <= 0 next edge.
- Timeout:
  - In RECV the timeout counter increments each cycle without stb and clears on stb.
  - At terminal count: pulse timeout_o, go to HUNT, clear the counters and the partial word. valid_o is unaffected.
  - The counter is held at 0 in HUNT.
- Simultaneous events:
  - stb and timeout terminal count in the same cycle: stb wins, counter clears.
  - Sync match and en_i = 0 in the same cycle: en_i wins.
- locked_o = (state == RECV), registered.

Optional Feature:
- Macro PARITY_CHECK_EN.
- When defined:
  - Each word in RECV is followed by one even-parity bit; bit_cnt counts DW+1 bits.
  - The parity bit is excluded from word_o.
  - On mismatch: parity_err_o pulses one cycle after the parity-bit stb. The word is discarded: no valid_o and no overrun_o, but word_cnt still increments.
- When undefined: parity_err_o is tied to 0 and words are DW bits.

Test Plan:
- Sync then frame: send bits of 8'hD5, then 8'h3C, 8'hA5, 8'h00, 8'hFF with ready_i = 1 -> locked_o rises 1 cycle after the last sync stb. Four valid_o pulses with words 3C, A5, 00, FF. frame_end_o on the FF load; locked_o falls.
- Backpressure: ready_i = 0 for the whole frame -> word_o = 3C stays valid and overrun_o pulses 3 times. Then ready_i = 1 -> valid_o clears next edge.
- False sync: send 8'hD4 followed by 8'hD5 -> no lock after D4; lock after the final bit of D5.
- Clock loss: hold clk_rec_i high for 255 cycles after 3 bits of a word in RECV (TMO_W = 8) -> timeout_o pulse, state HUNT, no valid_o.
- Reset mid-frame: assert rst_n_i low during the 5th bit of word 2 -> all outputs 0 immediately. After release, data without sync yields no valid_o.
- PARITY_CHECK_EN: sync, then 8'h3C with parity 1 (wrong) and 8'hA5 with parity 0 (correct) -> parity_err_o pulse on the first word, valid_o only for A5.

Source files
------------

// File: rtl/bit_deserializer.sv
// Mid-bit sampler and frame deserializer: it hunts for a sync pattern, then shifts out FRAME_WORDS words on a valid/ready port.
// Optional even-parity bit per word is enabled by defining PARITY_CHECK_EN.
module bit_deserializer #(
  parameter int              DW          = 8,
  parameter int              SYNC_W      = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 8'hD5,
  parameter int              FRAME_WORDS = 4,
  parameter int              TMO_W       = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          data_i,
  input  logic          clk_rec_i,
  input  logic          en_i,
  output logic [DW-1:0] word_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          locked_o,
  output logic          frame_end_o,
  output logic          overrun_o,
  output logic          timeout_o,
  output logic          parity_err_o
);

`ifdef PARITY_CHECK_EN
  localparam int WBITS = DW + 1;
`else
  localparam int WBITS = DW;
`endif
  localparam int BCW = $clog2(WBITS);
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BCW-1:0]   BIT_LAST  = BCW'(WBITS - 1);
  localparam logic [WCW-1:0]   WORD_LAST = WCW'(FRAME_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  // Handshake: a word transfers on any clk_i edge where valid_o && ready_i;
  // valid_o and word_o hold steady until that transfer occurs.
  state_t            state;
  logic              clk_rec_q;
  logic [SYNC_W-1:0] sync_sr;
  logic [DW-1:0]     data_sr;
  logic [BCW-1:0]    bit_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              stb;
  logic              last_bit;
  logic              complete;
  logic              deliver;
  logic [SYNC_W-1:0] sync_next;
  logic [DW-1:0]     new_word;

  assign stb       = clk_rec_q & ~clk_rec_i;
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign sync_next = {sync_sr[SYNC_W-2:0], data_i};
  assign complete  = en_i && (state == RECV) && stb && last_bit;

`ifdef PARITY_CHECK_EN
  logic word_ok;
  // On the parity stb data_sr already holds the full word and data_i is the parity bit.
  assign new_word = data_sr;
  assign word_ok  = ((^data_sr) == data_i);
  assign deliver  = complete && word_ok;
`else
  assign new_word = {data_sr[DW-2:0], data_i};
  assign deliver  = complete;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= HUNT;
      locked_o     <= 1'b0;
      clk_rec_q    <= 1'b0;
      sync_sr      <= '0;
      data_sr      <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      tmo_cnt      <= '0;
      frame_end_o  <= 1'b0;
      timeout_o    <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      clk_rec_q   <= clk_rec_i;
      frame_end_o <= 1'b0;
      timeout_o   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_o <= 1'b0;
`endif
      if (!en_i) begin
        state    <= HUNT;
        locked_o <= 1'b0;
        sync_sr  <= '0;
        data_sr  <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        case (state)
          HUNT: begin
            tmo_cnt <= '0;
            if (stb) begin
              sync_sr <= sync_next;
              if (sync_next == SYNC_PAT) begin
                state    <= RECV;
                locked_o <= 1'b1;
                bit_cnt  <= '0;
                word_cnt <= '0;
              end
            end
          end
          RECV: begin
            if (stb) begin
              tmo_cnt <= '0;
`ifdef PARITY_CHECK_EN
              if (!last_bit) data_sr <= {data_sr[DW-2:0], data_i};
              if (last_bit && !word_ok) parity_err_o <= 1'b1;
`else
              data_sr <= {data_sr[DW-2:0], data_i};
`endif
              if (last_bit) begin
                bit_cnt <= '0;
                if (word_cnt == WORD_LAST) begin
                  frame_end_o <= 1'b1;
                  sync_sr     <= '0;
                  word_cnt    <= '0;
                  state       <= HUNT;
                  locked_o    <= 1'b0;
                end else begin
                  word_cnt <= word_cnt + WCW'(1);
                end
              end else begin
                bit_cnt <= bit_cnt + BCW'(1);
              end
            end else if (tmo_cnt == TMO_LAST) begin
              // Stb wins over the terminal count because this branch only runs without stb.
              timeout_o <= 1'b1;
              state     <= HUNT;
              locked_o  <= 1'b0;
              data_sr   <= '0;
              bit_cnt   <= '0;
              word_cnt  <= '0;
              tmo_cnt   <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifndef PARITY_CHECK_EN
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (deliver) begin
        if (!valid_o || ready_i) begin
          word_o  <= new_word;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer: a bit-stream level reference model is compared every cycle,
// plus literal expectations on accepted words and event counts.
module tb_bit_deserializer;
  localparam int DW = 8;
  localparam int SYNC_W = 8;
  localparam int SYNC_PAT = 8'hD5;
  localparam int FRAME_WORDS = 4;
  localparam int TMO_W = 8;
`ifdef PARITY_CHECK_EN
  localparam int WB = DW + 1;
`else
  localparam int WB = DW;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data = 1'b0;
  logic clk_rec = 1'b0;
  logic en = 1'b1;
  logic ready = 1'b1;
  logic [DW-1:0] word_o;
  logic valid_o, locked_o, frame_end_o, overrun_o, timeout_o, parity_err_o;

  int checks = 0;
  int errors = 0;

  bit_deserializer #(.DW(DW), .SYNC_W(SYNC_W), .SYNC_PAT(8'hD5), .FRAME_WORDS(FRAME_WORDS), .TMO_W(TMO_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .clk_rec_i(clk_rec), .en_i(en),
    .word_o(word_o), .valid_o(valid_o), .ready_i(ready), .locked_o(locked_o),
    .frame_end_o(frame_end_o), .overrun_o(overrun_o), .timeout_o(timeout_o),
    .parity_err_o(parity_err_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the received bit stream, not the RTL registers.
  bit m_prev, m_locked;
  int m_hist, m_words, m_idle;
  bit m_bits[$];
  logic e_valid, e_fe, e_ovr, e_tmo, e_perr;
  logic [DW-1:0] e_word;

  always @(posedge clk or negedge rst_n) begin
    bit stb, done, ok;
    int w, ones;
    if (!rst_n) begin
      m_prev = 0; m_locked = 0; m_hist = 0; m_words = 0; m_idle = 0; m_bits.delete();
      e_valid = 0; e_fe = 0; e_ovr = 0; e_tmo = 0; e_perr = 0; e_word = '0;
    end else begin
      stb = m_prev && !clk_rec;
      m_prev = clk_rec;
      e_fe = 0; e_ovr = 0; e_tmo = 0; e_perr = 0;
      done = 0; ok = 1; w = 0; ones = 0;
      if (!en) begin
        m_locked = 0; m_hist = 0; m_words = 0; m_idle = 0; m_bits.delete();
      end else if (!m_locked) begin
        m_idle = 0;
        if (stb) begin
          m_hist = ((m_hist * 2) + int'(data)) % (1 << SYNC_W);
          if (m_hist == SYNC_PAT) begin
            m_locked = 1; m_words = 0; m_bits.delete();
          end
        end
      end else if (stb) begin
        m_idle = 0;
        m_bits.push_back(data);
        if (m_bits.size() == WB) begin
          for (int i = 0; i < DW; i++) w = w * 2 + int'(m_bits[i]);
          for (int i = 0; i < WB; i++) ones += int'(m_bits[i]);
`ifdef PARITY_CHECK_EN
          ok = (ones % 2 == 0);
          if (!ok) e_perr = 1;
`endif
          done = 1;
          m_words++;
          m_bits.delete();
          if (m_words == FRAME_WORDS) begin
            e_fe = 1; m_locked = 0; m_hist = 0; m_words = 0;
          end
        end
      end else if (m_idle == (1 << TMO_W) - 2) begin
        e_tmo = 1; m_locked = 0; m_words = 0; m_idle = 0; m_bits.delete();
      end else begin
        m_idle++;
      end
      if (done && ok) begin
        if (!e_valid || ready) begin
          e_word = DW'(w); e_valid = 1;
        end else begin
          e_ovr = 1;
        end
      end else if (e_valid && ready) begin
        e_valid = 0;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("valid", valid_o, e_valid);
    chk("locked", locked_o, m_locked);
    chk("frame_end", frame_end_o, e_fe);
    chk("overrun", overrun_o, e_ovr);
    chk("timeout", timeout_o, e_tmo);
    chk("parity_err", parity_err_o, e_perr);
    if (e_valid) chk("word", word_o, e_word);
  end

  // scoreboard of literal expected words, plus event counters
  logic [DW-1:0] exp_q[$];
  int acc_cnt = 0, ovr_cnt = 0, fe_cnt = 0, tmo_cnt = 0, perr_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("unexpected_word", word_o, 32'hFFFF_FFFF);
        else chk("acc_word", word_o, exp_q.pop_front());
      end
      if (overrun_o) ovr_cnt++;
      if (frame_end_o) fe_cnt++;
      if (timeout_o) tmo_cnt++;
      if (parity_err_o) perr_cnt++;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    clk_rec = 1'b1; data = b;
    idle(1);
    @(negedge clk);
    clk_rec = 1'b0;
    idle(1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_word_p(input logic [DW-1:0] v, input logic p);
    for (int i = DW - 1; i >= 0; i--) send_bit(v[i]);
`ifdef PARITY_CHECK_EN
    send_bit(p);
`else
    if (p) ; // parity bit only exists in the parity build
`endif
  endtask

  task automatic send_word(input logic [DW-1:0] v);
    send_word_p(v, ^v);
  endtask

  int acc0, ovr0, tmo0;

  initial begin
    idle(3);
    chk("rst_valid", valid_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_word", word_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // sync then a full frame
    exp_q.push_back(8'h3C); exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    send_byte(8'hD5);
    chk("lock_after_sync", locked_o, 1);
    send_word(8'h3C); send_word(8'hA5); send_word(8'h00); send_word(8'hFF);
    idle(4);
    chk("frame_acc", acc_cnt, 4);
    chk("frame_end_cnt", fe_cnt, 1);
    chk("unlock_after_frame", locked_o, 0);

    // backpressure for the whole frame
    ready = 1'b0; ovr0 = ovr_cnt;
    exp_q.push_back(8'h3C);
    send_byte(8'hD5);
    send_word(8'h3C); send_word(8'hA5); send_word(8'h00); send_word(8'hFF);
    idle(2);
    chk("bp_overruns", ovr_cnt - ovr0, 3);
    chk("bp_valid_held", valid_o, 1);
    chk("bp_word_held", word_o, 8'h3C);
    ready = 1'b1;
    idle(1);
    chk("bp_valid_clear", valid_o, 0);

    // false sync, then real sync
    send_byte(8'hD4);
    chk("no_lock_d4", locked_o, 0);
    send_byte(8'hD5);
    chk("lock_d5", locked_o, 1);

    // clock loss after three bits
    acc0 = acc_cnt; tmo0 = tmo_cnt;
    send_bit(1); send_bit(0); send_bit(1);
    clk_rec = 1'b1;
    idle(300);
    chk("tmo_pulses", tmo_cnt - tmo0, 1);
    chk("tmo_unlocked", locked_o, 0);
    chk("tmo_no_word", acc_cnt - acc0, 0);

    // enable drop while locked
    send_byte(8'hD5);
    chk("en_pre_lock", locked_o, 1);
    en = 1'b0;
    idle(2);
    chk("en_unlock", locked_o, 0);
    en = 1'b1;

    // reset in the middle of word 2
    exp_q.push_back(8'h3C);
    send_byte(8'hD5);
    send_word(8'h3C);
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    @(negedge clk);
    clk_rec = 1'b1; data = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_locked", locked_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_word", word_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc0 = acc_cnt;
    send_byte(8'h3C); send_byte(8'hA5);
    idle(2);
    chk("post_rst_no_word", acc_cnt - acc0, 0);
    chk("post_rst_unlocked", locked_o, 0);

`ifdef PARITY_CHECK_EN
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    acc0 = acc_cnt;
    send_byte(8'hD5);
    send_word_p(8'h3C, 1'b1);
    send_word_p(8'hA5, 1'b0);
    send_word(8'h00); send_word(8'hFF);
    idle(4);
    chk("parity_errs", perr_cnt, 1);
    chk("parity_acc", acc_cnt - acc0, 3);
`else
    chk("no_parity_errs", perr_cnt, 0);
`endif

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
